log_mul_pipe: RTL

LOG_MUL_PIPE -- requirements
Module: log_mul_pipe

---
 rtl/log_mul_pipe.sv | 124 ++++++++++++
 1 files changed

// File: rtl/log_mul_pipe.sv
// Two-stage, multi-lane log-domain multiplier: products are sums of signed fixed-point logs.
// Build option LOG_MUL_SATURATE_EN: overflow clamps to max finite magnitude instead of inf.
module log_mul_pipe #(
  parameter int unsigned M     = 3,
  parameter int unsigned F     = 4,
  parameter int unsigned LANES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [LANES*(3+M+F)-1:0] inA,
  input  logic [LANES*(3+M+F)-1:0] inB,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [LANES*(3+M+F)-1:0] out,
  output logic [15:0]              satCount
);

  localparam int unsigned W = 3 + M + F;
  localparam int unsigned N = M + F;
  localparam logic signed [N:0] SumMax = {2'b00, {(N - 1){1'b1}}};
  localparam logic signed [N:0] SumMin = {2'b11, {(N - 1){1'b0}}};

  logic                    s1_valid_q;
  logic [LANES-1:0]        s1_sign_q, s1_inf_q, s1_zero_q;
  logic signed [N:0]       s1_sum_q [LANES];
  logic signed [N:0]       sum_d [LANES];

  logic                    out_valid_q;
  logic [LANES*W-1:0]      out_q, res_d;
  logic [LANES-1:0]        ev_q, ev_d;
  logic [15:0]             sat_q, sat_d;
  logic [16:0]             ev_cnt, sat_sum;

  logic s1_en, s2_en;

  assign s2_en    = !out_valid_q || outReady;
  assign s1_en    = !s1_valid_q || s2_en;
  assign inReady  = s1_en;
  assign outValid = out_valid_q;
  assign out      = out_q;
  assign satCount = sat_q;

  // Sign-extend each (M+F)-bit log value by one bit so the sum cannot wrap.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum_d[i] = {inA[i*W + N - 1], inA[i*W +: N]} + {inB[i*W + N - 1], inB[i*W +: N]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else if (s1_en) begin
      s1_valid_q <= inValid;
    end
  end

  always_ff @(posedge clock) begin
    if (s1_en && inValid) begin
      for (int i = 0; i < LANES; i++) begin
        s1_sign_q[i] <= inA[i*W + W - 1] ^ inB[i*W + W - 1];
        s1_inf_q[i]  <= inA[i*W + W - 2] | inB[i*W + W - 2];
        s1_zero_q[i] <= inA[i*W + W - 3] | inB[i*W + W - 3];
        s1_sum_q[i]  <= sum_d[i];
      end
    end
  end

  // Inf beats zero; range events only count for finite non-zero operands.
  always_comb begin
    res_d = '0;
    ev_d  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_inf_q[i]) begin
        res_d[i*W +: W] = {1'b0, 1'b1, 1'b0, {N{1'b0}}};
      end else if (s1_zero_q[i]) begin
        res_d[i*W +: W] = {1'b0, 1'b0, 1'b1, {N{1'b0}}};
      end else if (s1_sum_q[i] < SumMin) begin
        res_d[i*W +: W] = {1'b0, 1'b0, 1'b1, {N{1'b0}}};
        ev_d[i]         = 1'b1;
      end else if (s1_sum_q[i] > SumMax) begin
`ifdef LOG_MUL_SATURATE_EN
        res_d[i*W +: W] = {s1_sign_q[i], 2'b00, 1'b0, {(N - 1){1'b1}}};
`else
        res_d[i*W +: W] = {1'b0, 1'b1, 1'b0, {N{1'b0}}};
`endif
        ev_d[i]         = 1'b1;
      end else begin
        res_d[i*W +: W] = {s1_sign_q[i], 2'b00, s1_sum_q[i][N-1:0]};
      end
    end
  end

  always_comb begin
    ev_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      ev_cnt = ev_cnt + 17'(ev_q[i]);
    end
    sat_sum = {1'b0, sat_q} + ev_cnt;
    sat_d   = (sat_sum > 17'h0FFFF) ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      sat_q       <= '0;
    end else begin
      if (s2_en) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_q <= res_d;
          ev_q  <= ev_d;
        end
      end
      if (out_valid_q && outReady) begin
        sat_q <= sat_d;
      end
    end
  end

endmodule
